// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation controller for the 4-bit AD path.
// Drives a trial code into the DAC, samples the external comparator and
// resolves one bit per trial step, MSB first, with a start/done handshake.
// Optional build macro: ADC_INV_OUT_EN drives the result port inverted
// (reset value all ones). The dac_code polarity is unaffected.
module sar_adc_ctrl #(
    parameter int unsigned WIDTH  = 4,  // result bits, >= 2
    parameter int unsigned SETTLE = 1   // extra hold cycles per trial code
) (
    input  logic             clk_i,
    input  logic             reset_i,    // asynchronous, active-high
    input  logic             start_i,
    input  logic             comp_i,     // 1 = vin >= DAC(dac_code_o)
    output logic [WIDTH-1:0] dac_code_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    // Counter must be at least one bit wide even when SETTLE is zero.
    localparam int unsigned CntW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int unsigned IdxW = $clog2(WIDTH);

    localparam logic [CntW-1:0]  CntLast = CntW'(SETTLE);
    localparam logic [IdxW-1:0]  IdxMsb  = IdxW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MsbCode = {1'b1, {(WIDTH - 1){1'b0}}};

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StTrial = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state: launch on start in idle, resolve one bit per trial, pulse done.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        result_d = result_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StTrial;
                    code_d  = MsbCode;
                    idx_d   = IdxMsb;
                    cnt_d   = '0;
                end
            end
            StTrial: begin
                if (cnt_q != CntLast) begin
                    // Hold the trial code while the DAC and comparator settle.
                    cnt_d = cnt_q + CntW'(1);
                end else begin
                    // Last hold cycle: comparator decides the current bit.
                    code_d[idx_q] = comp_i;
                    cnt_d         = '0;
                    if (idx_q != '0) begin
                        code_d[idx_q - IdxW'(1)] = 1'b1;
                        idx_d                    = idx_q - IdxW'(1);
                    end else begin
                        result_d = code_d;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Status flags are registered copies of the next state.
        busy_d = (state_d == StTrial);
        done_d = (state_d == StDone);
    end

    // State and datapath registers; reset aborts any conversion immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            code_q   <= '0;
            result_q <= '0;
            idx_q    <= IdxMsb;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign dac_code_o = code_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

`ifdef ADC_INV_OUT_EN
    assign result_o = ~result_q;
`else
    assign result_o = result_q;
`endif

endmodule
